pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor_if.sv | 34 +++
 rtl/pll_lock_supervisor.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL / downstream logic.
// The master side is the supervisor; the slave side is the PLL and system environment.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;

  modport master (
    input  pll_locked,
    input  soft_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail,
    output retry_cnt,
    output unlock_cnt
  );

  modport slave (
    output pll_locked,
    output soft_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail,
    input  retry_cnt,
    input  unlock_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset pulses, waits for a stable synchronized lock, retries on timeout,
// and releases the downstream system reset once lock has been stable long enough.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 7
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.master bus
);

  localparam logic [19:0] RstLoad     = 20'(RST_CYCLES);
  localparam logic [19:0] StableLoad  = 20'(STABLE_CYCLES);
  localparam logic [19:0] TimeoutLoad = 20'(TIMEOUT_CYCLES);
  localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPulse,
    StWait,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  unlock_q, unlock_d;
  logic        pll_rst_q, pll_rst_d;
  logic        ready_q, ready_d;
  logic        sys_rst_q, sys_rst_d;
  logic        fail_q, fail_d;
  logic        lk_meta_q, lk_q;
  logic [1:0]  rst_sync_q;
  logic        run_en;

  // Reset asserts asynchronously but is released to the sequencer only after two refclk edges.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_en = rst_sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= bus.pll_locked;
      lk_q      <= lk_meta_q;
    end
  end

  // cnt holds the cycles remaining in the current timed state, so a load of N gives N cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    unlock_d = unlock_q;

    if (!run_en || bus.soft_req) begin
      state_d = StPulse;
      cnt_d   = RstLoad;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        StPulse: begin
          if (cnt_q == 20'd1) begin
            state_d = StWait;
            cnt_d   = TimeoutLoad;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        StWait: begin
          if (lk_q) begin
            state_d = StStable;
            cnt_d   = StableLoad;
          end else if (cnt_q == 20'd1) begin
            if (retry_q < MaxRetries) begin
              state_d = StPulse;
              cnt_d   = RstLoad;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = StFail;
            end
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        StStable: begin
          if (!lk_q) begin
            state_d = StWait;
            cnt_d   = TimeoutLoad;
          end else if (cnt_q == 20'd1) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        StRun: begin
          if (!lk_q) begin
            state_d = StPulse;
            cnt_d   = RstLoad;
            retry_d = 4'd0;
            if (unlock_q != 8'hFF) begin
              unlock_d = unlock_q + 8'd1;
            end
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StPulse;
          cnt_d   = RstLoad;
        end
      endcase
    end
  end

  // Outputs decode the next state so they land on the same edge as the state itself.
  always_comb begin
    pll_rst_d = (state_d == StPulse) || (state_d == StFail);
    ready_d   = (state_d == StRun);
    sys_rst_d = !ready_d;
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPulse;
      cnt_q     <= RstLoad;
      retry_q   <= 4'd0;
      unlock_q  <= 8'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      unlock_q  <= unlock_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      sys_rst_q <= sys_rst_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.ready      = ready_q;
  assign bus.sys_rst    = sys_rst_q;
  assign bus.fail       = fail_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.unlock_cnt = unlock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST=4, STABLE=8, TIMEOUT=20, MAX_RETRIES=2.
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_lock_supervisor;

  logic refclk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n;
  int   relocks;
  int   bad_samples;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(20),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge refclk);
  endtask

  // Length of the current run of pll_rst at level lvl, including the present sample.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (bus.pll_rst === lvl && len < 200) begin
      len++;
      tick();
    end
  endtask

  task automatic wait_ready(output int len);
    len = 0;
    while (bus.ready !== 1'b1 && len < 100) begin
      tick();
      len++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pll_rst"}, int'(bus.pll_rst), 1);
    check_eq({tag, "_sys_rst"}, int'(bus.sys_rst), 1);
    check_eq({tag, "_ready"}, int'(bus.ready), 0);
    check_eq({tag, "_fail"}, int'(bus.fail), 0);
    check_eq({tag, "_retry"}, int'(bus.retry_cnt), 0);
    check_eq({tag, "_unlock"}, int'(bus.unlock_cnt), 0);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.soft_req   = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Nominal: 2 reset-sync edges plus a 4-cycle pulse, so pll_rst falls on edge 6.
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.pll_rst === 1'b1 && n < 50);
    check_eq("nom_pll_rst_fall_edge", n, 6);
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    // 2 synchronizer edges, then ready 9 edges after lk rises.
    wait_ready(n);
    check_eq("nom_ready_latency", n, 11);
    check_eq("nom_retry", int'(bus.retry_cnt), 0);
    check_eq("nom_sys_rst", int'(bus.sys_rst), 0);
    check_eq("nom_pll_rst", int'(bus.pll_rst), 0);

    // Single-cycle loss of lock in RUN.
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    tick();
    check_eq("loss_ready_before", int'(bus.ready), 1);
    tick();
    check_eq("loss_ready", int'(bus.ready), 0);
    check_eq("loss_sys_rst", int'(bus.sys_rst), 1);
    check_eq("loss_unlock", int'(bus.unlock_cnt), 1);
    check_eq("loss_retry", int'(bus.retry_cnt), 0);
    run_len(1'b1, n);
    check_eq("loss_pulse_len", n, 4);
    wait_ready(n);
    check_eq("loss_relock_latency", n, 9);

    // 299 further losses saturate unlock_cnt.
    relocks = 0;
    for (int i = 0; i < 299; i++) begin
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      repeat (2) tick();
      wait_ready(n);
      if (bus.ready === 1'b1) relocks++;
    end
    check_eq("sat_relocks", relocks, 299);
    check_eq("sat_unlock", int'(bus.unlock_cnt), 255);

    // Lock glitch in STABLE: lk low for 3 cycles must not pulse or reach RUN.
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    check_eq("glitch_soft_ready", int'(bus.ready), 0);
    check_eq("glitch_soft_pll_rst", int'(bus.pll_rst), 1);
    run_len(1'b1, n);
    check_eq("glitch_pulse_len", n, 4);
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    bad_samples = 0;
    repeat (3) begin
      tick();
      if (bus.pll_rst !== 1'b0 || bus.ready !== 1'b0) bad_samples++;
    end
    bus.pll_locked = 1'b1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.pll_rst !== 1'b0) bad_samples++;
    end
    check_eq("glitch_bad_samples", bad_samples, 0);
    check_eq("glitch_ready_latency", n, 11);
    check_eq("glitch_retry", int'(bus.retry_cnt), 0);

    // Never lock: three pulses spaced by 20 WAIT cycles, then FAIL.
    bus.pll_locked = 1'b0;
    bus.soft_req   = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    check_eq("nl_unlock_kept", int'(bus.unlock_cnt), 255);
    for (int i = 0; i < 3; i++) begin
      check_eq("nl_retry", int'(bus.retry_cnt), i);
      run_len(1'b1, n);
      check_eq("nl_pulse_len", n, 4);
      run_len(1'b0, n);
      check_eq("nl_wait_len", n, 20);
    end
    check_eq("nl_fail", int'(bus.fail), 1);
    check_eq("nl_fail_pll_rst", int'(bus.pll_rst), 1);
    check_eq("nl_fail_retry", int'(bus.retry_cnt), 2);
    repeat (5) tick();
    check_eq("nl_fail_sticky", int'(bus.fail), 1);
    check_eq("nl_fail_pll_rst_sticky", int'(bus.pll_rst), 1);
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    check_eq("nl_soft_fail", int'(bus.fail), 0);
    check_eq("nl_soft_retry", int'(bus.retry_cnt), 0);
    run_len(1'b1, n);
    check_eq("nl_soft_pulse_len", n, 4);

    // soft_req on the exhausted-retry timeout edge wins over entering FAIL.
    run_len(1'b0, n);
    check_eq("race_wait_len0", n, 20);
    run_len(1'b1, n);
    check_eq("race_pulse_len1", n, 4);
    run_len(1'b0, n);
    check_eq("race_wait_len1", n, 20);
    run_len(1'b1, n);
    check_eq("race_pulse_len2", n, 4);
    repeat (19) tick();
    check_eq("race_last_wait_pll_rst", int'(bus.pll_rst), 0);
    check_eq("race_last_wait_retry", int'(bus.retry_cnt), 2);
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    check_eq("race_fail", int'(bus.fail), 0);
    check_eq("race_pll_rst", int'(bus.pll_rst), 1);
    check_eq("race_retry", int'(bus.retry_cnt), 0);
    bus.pll_locked = 1'b1;
    run_len(1'b1, n);
    check_eq("race_pulse_len", n, 4);
    check_eq("race_fail_after", int'(bus.fail), 0);
    wait_ready(n);
    check_eq("race_ready", int'(bus.ready), 1);

    // Asynchronous reset mid-RUN takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
